// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared types and default widths for the memory port arbiter
package multicore_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_LEN_W  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority one-hot picker
module rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IDX_W      = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    logic [IDX_W-1:0]     shift;
    logic [2*NUM_REQ-1:0] fwd;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   pick;
    logic [2*NUM_REQ-1:0] back;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        shift = (FIXED_PRIO != 0) ? '0 : ptr;
        fwd   = {req, req} >> shift;
        rot   = fwd[NUM_REQ-1:0];
        pick  = rot & (~rot + NUM_REQ'(1));
        back  = {pick, pick} << shift;
        gnt   = back[2*NUM_REQ-1:NUM_REQ];
        any   = |req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one burst memory port between NUM_REQ cache requesters
module mem_port_arbiter
    import multicore_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int LEN_W      = MEM_LEN_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic                      i_aclk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_wr_ack,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_rdata,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [LEN_W-1:0]          o_mem_len,
    input  logic                      i_mem_req_ready,
    output logic                      o_mem_wvalid,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic                      i_mem_wready,
    input  logic                      i_mem_rvalid,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    output logic                      o_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   ptr_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               err_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_any;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [DATA_W-1:0]  owner_wdata;
    logic               wr_beat;
    logic               rd_beat;
    logic               last_beat;
    logic               stray;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (IDX_W),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arbiter (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        sel_idx     = '0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_len     = '0;
        owner_wdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_gnt[r]) begin
                sel_idx  = IDX_W'(r);
                sel_we   = i_req_we[r];
                sel_addr = i_req_addr[r*ADDR_W +: ADDR_W];
                sel_len  = i_req_len[r*LEN_W +: LEN_W];
            end
            if (gnt_q[r]) begin
                owner_wdata = i_req_wdata[r*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_beat   = (state_q == WDATA) && i_mem_wready;
    assign rd_beat   = (state_q == RDATA) && i_mem_rvalid;
    assign last_beat = (wr_beat || rd_beat) && (cnt_q == '0);
    assign stray     = (i_mem_rvalid && (state_q != RDATA)) ||
                       (i_mem_wready && (state_q != WDATA));
    assign ptr_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (stray) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        owner_q <= sel_idx;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        len_q   <= sel_len;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_mem_req_ready) begin
                        cnt_q   <= len_q;
                        state_q <= we_q ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    // The burst runs to completion even if the owner drops i_req.
                    if (wr_beat || rd_beat) begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            ptr_q   <= ptr_next;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt        = gnt_q;
    assign o_mem_req    = (state_q == ADDR);
    assign o_mem_we     = (state_q == ADDR) ? we_q   : 1'b0;
    assign o_mem_addr   = (state_q == ADDR) ? addr_q : '0;
    assign o_mem_len    = (state_q == ADDR) ? len_q  : '0;
    assign o_mem_wvalid = (state_q == WDATA);
    assign o_mem_wdata  = (state_q == WDATA) ? owner_wdata : '0;
    assign o_wr_ack     = wr_beat   ? gnt_q : '0;
    assign o_rsp_valid  = rd_beat   ? gnt_q : '0;
    assign o_rsp_rdata  = (state_q == RDATA) ? i_mem_rdata : '0;
    assign o_done       = last_beat ? gnt_q : '0;
    assign o_err        = err_q;

endmodule
